fetch_cycle: RTL

FETCH_CYCLE -- requirements
Module: fetch_cycle

---
 rtl/fetch_cycle.sv | 73 +++++++
 1 files changed

// File: rtl/fetch_cycle.sv
// fetch_cycle: IF stage with PC register, IF/ID pipeline register and optional bimodal predictor.
// Define BRANCH_PREDICT_EN to enable the 16-entry 2-bit counter predictor; otherwise fetch is PC+4 with redirects.
module fetch_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] InstrF,
   output logic [31:0] PCF,
   input  logic        MispredictE,
   input  logic [31:0] PCRedirectE,
   input  logic        BranchResolveE,
   input  logic        BranchTakenE,
   input  logic [31:0] PCE,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        PredTakenD
);
   logic [31:0] r_pc, r_instr_d, r_pc_d, r_pc4_d;
   logic        r_pred_d;
   logic [31:0] w_pc4, w_pc_next;
   logic        w_pred;
   logic        w_unused;
   assign w_pc4 = r_pc + 32'd4;
`ifdef BRANCH_PREDICT_EN
   logic [1:0]  r_cnt [16];
   logic [1:0]  w_cnt_old;
   logic [3:0]  w_upd_idx;
   logic        w_is_b, w_is_jal;
   logic [31:0] w_imm, w_target;
   assign w_is_b    = InstrF[6:0] == 7'b1100011;
   assign w_is_jal  = InstrF[6:0] == 7'b1101111;
   assign w_imm     = w_is_jal ? {{12{InstrF[31]}}, InstrF[19:12], InstrF[20], InstrF[30:21], 1'b0}
                               : {{20{InstrF[31]}}, InstrF[7], InstrF[30:25], InstrF[11:8], 1'b0};
   assign w_target  = r_pc + w_imm;
   // lookup reads the registered table, so a same-cycle update is only seen next cycle
   assign w_pred    = w_is_jal | (w_is_b & r_cnt[r_pc[5:2]][1]);
   assign w_upd_idx = PCE[5:2];
   assign w_cnt_old = r_cnt[w_upd_idx];
   assign w_unused  = ^{PCE[31:6], PCE[1:0]};
   always_ff @(posedge clk)
      if (rst) r_cnt <= '{default: 2'b01};
      else if (BranchResolveE)
         r_cnt[w_upd_idx] <= BranchTakenE ? (w_cnt_old == 2'b11 ? 2'b11 : w_cnt_old + 2'd1)
                                          : (w_cnt_old == 2'b00 ? 2'b00 : w_cnt_old - 2'd1);
   assign w_pc_next = MispredictE ? PCRedirectE : StallF ? r_pc : w_pred ? w_target : w_pc4;
`else
   assign w_unused  = ^{BranchResolveE, BranchTakenE, PCE};
   assign w_pred    = 1'b0;
   assign w_pc_next = MispredictE ? PCRedirectE : StallF ? r_pc : w_pc4;
`endif
   always_ff @(posedge clk)
      r_pc <= rst ? 32'h0 : w_pc_next;
   always_ff @(posedge clk)
      if (rst || FlushD) begin
         r_instr_d <= 32'h0000_0013;
         r_pc_d    <= 32'h0;
         r_pc4_d   <= 32'h0;
         r_pred_d  <= 1'b0;
      end else if (!StallD) begin
         r_instr_d <= InstrF;
         r_pc_d    <= r_pc;
         r_pc4_d   <= w_pc4;
         r_pred_d  <= w_pred;
      end
   assign PCF        = r_pc;
   assign InstrD     = r_instr_d;
   assign PCD        = r_pc_d;
   assign PCPlus4D   = r_pc4_d;
   assign PredTakenD = r_pred_d;
endmodule
